ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the sending side of the PS/2 keyboard link whose receive side already feeds the LCD/7-seg path.
//  Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over open-drain clock/data and checks the device ACK.
//  Sits beside PS2_Interface in skeleton. Drives the pad enables; busy tells the receiver to discard bits during a transfer.
// PARAMETERS
//  INHIBIT_CYCLES       5000    clock held low before request-to-send (100 us @ 50 MHz)
//  SETUP_CYCLES         50      data held low with clock still low, before clock release (1 us)
//  START_TIMEOUT_CYCLES 750000  max wait from clock release to first device falling edge (15 ms)
//  XFER_TIMEOUT_CYCLES  100000  max duration from first device edge to end of ACK (2 ms)
// PORTS
//  clock        in   1  system clock (50 MHz)
//  reset        in   1  asynchronous, active-high reset
//  tx_data      in   8  command byte, sampled when tx_valid & tx_ready
//  tx_valid     in   1  request to send tx_data
//  tx_ready     out  1  1 only in IDLE
//  tx_done      out  1  1-cycle pulse: byte sent and ACK received
//  tx_error     out  1  1-cycle pulse: transfer failed, code in err_code
//  err_code     out  2  01 start timeout, 10 transfer timeout, 11 NACK; holds until next accept
//  busy         out  1  1 in every state except IDLE
//  ps2_clk_in   in   1  raw PS/2 clock pad level (asynchronous)
//  ps2_data_in  in   1  raw PS/2 data pad level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull clock pad low; 0 = release
//  ps2_data_oe  out  1  1 = pull data pad low; 0 = release
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. oe outputs, tx_done, tx_error, err_code and busy all 0. tx_ready=1. Pads released immediately.
//  Inputs: 2-FF sync on clk/data. Falling edge = prev sync clk 1 and current 0. Edge seen 3 cycles after the pad edge.
//  Frame shift reg: {stop=1, parity, data[7:0]}, loaded on accept. Parity is odd: ~^tx_data. Bit 0 goes out first.
//  FSM:
//   IDLE: tx_ready=1. On tx_valid, latch the frame and clear err_code -> INHIBIT.
//   INHIBIT: clk_oe=1 for INHIBIT_CYCLES -> RTS.
//   RTS: clk_oe=1, data_oe=1 for SETUP_CYCLES -> REQ (start bit 0).
//   REQ: clk_oe=0, data_oe=1. First falling edge -> DATA; that edge drives data_oe=~frame[0] and sets bit_idx=1.
//        START_TIMEOUT_CYCLES without an edge -> ERROR(01).
//   DATA: on each falling edge, data_oe=~frame[bit_idx] and bit_idx++. Edges 1-8 = data, 9 = parity, 10 = stop (release).
//         At edge 10 (bit_idx==10 after) -> ACK.
//   ACK: data_oe=0. On the next (11th) falling edge, sample sync data: 0 -> WAIT_IDLE; 1 -> ERROR(11).
//   WAIT_IDLE: wait until sync clk=1 and data=1 -> IDLE, with a tx_done pulse that same cycle.
//  Xfer counter starts on the REQ->DATA edge. Reaching XFER_TIMEOUT_CYCLES in DATA/ACK/WAIT_IDLE -> ERROR(10).
//  ERROR: both oe=0, tx_error pulses 1 cycle, err_code set -> IDLE next cycle.
//  Data only changes on falling edges. Pad data is stable while the device clock is high.
//  tx_valid outside IDLE is ignored; nothing is queued. tx_valid in the same cycle as reset is dropped.
//  Counters are 20 bits, saturate at their compare value and reset on every state entry.
//  A device edge during INHIBIT/RTS is ignored.
// TESTING (bench params: INHIBIT=20, SETUP=4, START_TO=200, XFER_TO=2000; device model period 40 cycles)
//  1 Send 0xED, device ACKs -> sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
//    tx_done pulses once, tx_error=0, busy falls with done.
//  2 Send 0x01 -> parity 0. Send 0x00 -> parity 1. Both end with tx_done.
//  3 Device never clocks -> clk_oe high exactly 20 cycles, data_oe rises at cycle 20.
//    tx_error + err_code=01 at 20+4+200(+1) cycles after accept.
//  4 Device leaves data high on the 11th edge -> tx_error, err_code=11, no tx_done.
//  5 reset mid-DATA (after edge 4) -> both oe drop in the same cycle.
//    After release, tx_ready=1 and a new 0xFF transfer completes with parity 1.
//  6 tx_valid held high through a transfer with tx_data changing -> exactly one frame, carrying the first-accepted byte.
//    A second frame starts only after returning to IDLE.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-drain PS/2 pad signals
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, tx_done, tx_error, err_code, busy, ps2_clk_oe, ps2_data_oe
    );
    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, tx_done, tx_error, err_code, busy, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device and checks its ACK
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int SETUP_CYCLES         = 50,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
    input logic          clock,
    input logic          reset,
    ps2_host_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, REQ, DATA, ACK, WAIT_IDLE, ERROR} state_t;
    localparam logic [19:0] INH_MAX   = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] SETUP_MAX = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] START_MAX = 20'(START_TIMEOUT_CYCLES - 1);
    localparam logic [19:0] XFER_MAX  = 20'(XFER_TIMEOUT_CYCLES - 1);
    state_t      state, state_n;
    logic [19:0] cnt, cnt_lim, xcnt;
    logic [1:0]  clk_s, data_s, err_q, err_n;
    logic        clk_prev, fall, drv, in_xfer, xfer_to;
    logic [9:0]  frame;
    logic [3:0]  bit_idx;
    assign fall    = clk_prev & ~clk_s[1];
    assign in_xfer = state == DATA || state == ACK || state == WAIT_IDLE;
    assign xfer_to = xcnt == XFER_MAX;
    // state register; reset releases both pads at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // pad synchronisers, phase counters, frame and bit shifter, error code
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s    <= 2'b11;
            data_s   <= 2'b11;
            clk_prev <= 1'b1;
            cnt      <= '0;
            xcnt     <= '0;
            frame    <= '0;
            bit_idx  <= '0;
            drv      <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            clk_s    <= {clk_s[0], bus.ps2_clk_in};
            data_s   <= {data_s[0], bus.ps2_data_in};
            clk_prev <= clk_s[1];
            cnt      <= state_n != state ? '0 : cnt == cnt_lim ? cnt : cnt + 20'd1;
            xcnt     <= !in_xfer ? '0 : xfer_to ? xcnt : xcnt + 20'd1;
            err_q    <= err_n;
            if (state == IDLE && bus.tx_valid) frame <= {1'b1, ~^bus.tx_data, bus.tx_data};
            if (fall && state == REQ) begin
                drv     <= ~frame[0];
                bit_idx <= 4'd1;
            end else if (fall && state == DATA) begin
                drv     <= ~frame[bit_idx];
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end
    // next state, error code and pad/handshake outputs
    always_comb begin
        state_n      = state;
        err_n        = err_q;
        cnt_lim      = '0;
        bus.tx_done  = 1'b0;
        case (state)
            IDLE:    if (bus.tx_valid) begin
                         state_n = INHIBIT;
                         err_n   = 2'b00;
                     end
            INHIBIT: begin
                         cnt_lim = INH_MAX;
                         if (cnt == INH_MAX) state_n = RTS;
                     end
            RTS:     begin
                         cnt_lim = SETUP_MAX;
                         if (cnt == SETUP_MAX) state_n = REQ;
                     end
            REQ:     begin
                         cnt_lim = START_MAX;
                         if (fall) state_n = DATA;
                         else if (cnt == START_MAX) begin
                             state_n = ERROR;
                             err_n   = 2'b01;
                         end
                     end
            DATA:    if (xfer_to) begin
                         state_n = ERROR;
                         err_n   = 2'b10;
                     end else if (fall && bit_idx == 4'd9) state_n = ACK;
            ACK:     if (xfer_to) begin
                         state_n = ERROR;
                         err_n   = 2'b10;
                     end else if (fall) begin
                         state_n = data_s[1] ? ERROR : WAIT_IDLE;
                         err_n   = data_s[1] ? 2'b11 : err_q;
                     end
            WAIT_IDLE: if (xfer_to) begin
                         state_n = ERROR;
                         err_n   = 2'b10;
                     end else if (clk_s[1] && data_s[1]) begin
                         state_n     = IDLE;
                         bus.tx_done = 1'b1;
                     end
            ERROR:   state_n = IDLE;
        endcase
        bus.tx_ready    = state == IDLE;
        bus.busy        = state != IDLE;
        bus.tx_error    = state == ERROR;
        bus.err_code    = err_q;
        bus.ps2_clk_oe  = state == INHIBIT || state == RTS;
        bus.ps2_data_oe = state == RTS || state == REQ || (state == DATA && drv);
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed PS/2 host-transmit frames against a behavioural keyboard
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dev_clow = 1'b0;
    logic       dev_dlow = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] last_ec = 2'b00;
    logic       prev_done = 1'b0;
    logic       busy_after_done = 1'b1;
    logic [9:0] bits, bits2;
    int         d0, e0, inh, rise, errn, rdy_mid;
    logic [1:0] ec;
    logic       seen;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .SETUP_CYCLES(4),
        .START_TIMEOUT_CYCLES(200),
        .XFER_TIMEOUT_CYCLES(2000)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clow);
    assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_dlow);

    always #5 clk = ~clk;

    // count done/error pulses and see what busy does the cycle after done
    always @(negedge clk) begin
        if (bus.tx_done) done_cnt++;
        if (bus.tx_error) begin
            err_cnt++;
            last_ec = bus.err_code;
        end
        if (prev_done) busy_after_done = bus.busy;
        prev_done = bus.tx_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic dev_pulse(output logic b);
        dev_clow = 1'b1;
        repeat (20) @(negedge clk);
        b = bus.ps2_data_in;
        dev_clow = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_req();
        int w = 0;
        while (!(bus.ps2_data_oe && !bus.ps2_clk_oe) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("req_wait", 32'(w < 200), 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic dev_frame(input logic ack_low, output logic [9:0] b10);
        logic b;
        b10 = '0;
        wait_req();
        for (int k = 0; k < 10; k++) begin
            dev_pulse(b);
            b10[k] = b;
        end
        dev_dlow = ack_low;
        dev_pulse(b);
        dev_dlow = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (bus.busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("idle_wait", 32'(w < 300), 1);
        @(negedge clk);
    endtask

    task automatic good_frame(input string tag, input logic [7:0] d, input logic [9:0] exp);
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        dev_frame(1'b1, bits);
        wait_idle();
        check({tag, "_bits"}, 32'(bits), 32'(exp));
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"}, err_cnt - e0, 0);
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus.tx_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_clk_oe", 32'(bus.ps2_clk_oe), 0);
        check("rst_data_oe", 32'(bus.ps2_data_oe), 0);
        check("rst_err_code", 32'(bus.err_code), 0);
        check("rst_done_err", 32'({bus.tx_done, bus.tx_error}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        good_frame("ed", 8'hED, 10'h3ED);
        check("ed_busy_after_done", 32'(busy_after_done), 0);

        // parity flips with the number of ones
        good_frame("x01", 8'h01, 10'h201);
        good_frame("x00", 8'h00, 10'h300);

        // silent device: inhibit length, setup, start timeout
        send(8'h55);
        inh = 0; rise = 0; errn = 0; ec = 2'b00;
        for (int n = 1; n <= 400 && errn == 0; n++) begin
            if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh++;
            if (bus.ps2_data_oe && rise == 0) rise = n;
            if (bus.tx_error) begin
                errn = n;
                ec = bus.err_code;
            end
            @(negedge clk);
        end
        check("to_inhibit_len", inh, 20);
        check("to_data_oe_rise", rise, 21);
        check("to_error_cycle", errn, 225);
        check("to_err_code", 32'(ec), 1);
        check("to_err_code_hold", 32'(bus.err_code), 1);
        check("to_ready", 32'(bus.tx_ready), 1);

        // device NACK on the 11th edge
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h12);
        dev_frame(1'b0, bits);
        wait_idle();
        check("nack_err", err_cnt - e0, 1);
        check("nack_code", 32'(last_ec), 3);
        check("nack_done", done_cnt - d0, 0);

        // asynchronous reset in the middle of the data bits
        send(8'h00);
        wait_req();
        for (int k = 0; k < 4; k++) dev_pulse(seen);
        check("mid_data_oe", 32'(bus.ps2_data_oe), 1);
        #2 rst = 1'b1;
        bus.tx_data  = 8'h77;
        bus.tx_valid = 1'b1;
        #1;
        check("rst_async_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.tx_ready), 1);
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_err_code", 32'(bus.err_code), 0);
        good_frame("xff", 8'hFF, 10'h3FF);

        // tx_valid held with changing data: first byte only, then a second frame
        d0 = done_cnt;
        rdy_mid = 0;
        seen = 1'b0;
        @(negedge clk);
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        fork
            dev_frame(1'b1, bits);
            begin
                for (int i = 0; i < 1000 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.tx_ready) rdy_mid++;
                    if (bus.tx_done) seen = 1'b1;
                    else bus.tx_data = 8'(i * 37 + 1);
                end
                bus.tx_data = 8'h3C;
                @(negedge clk);
                check("hold_idle_gap", 32'(bus.tx_ready), 1);
                @(negedge clk);
                bus.tx_valid = 1'b0;
                check("hold_second_start", 32'(bus.busy), 1);
            end
        join
        dev_frame(1'b1, bits2);
        wait_idle();
        check("hold_first_bits", 32'(bits), 32'(10'h3A5));
        check("hold_ready_mid", rdy_mid, 0);
        check("hold_second_bits", 32'(bits2), 32'(10'h33C));
        check("hold_done", done_cnt - d0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
